// File: rtl/aesha_pkg.sv
// Shared constants and types for the AESHA streaming adapter.
// Word count, index width, FSM state encoding and mode/direction encodings.
package aesha_pkg;

    localparam int WORDS = 16;
    localparam int IDX_W = $clog2(WORDS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    localparam logic MODE_AES = 1'b1;
    localparam logic DIR_DEC  = 1'b1;

    typedef enum logic [1:0] {
        LOAD,
        LAUNCH,
        WAIT,
        DRAIN
    } adapter_state_t;

endpackage

// File: rtl/aesha_word_packer.sv
// 16-word register array with clear, indexed write, whole-block load and indexed read.
// Used once to pack the input block and once to hold/unpack the core result.
module aesha_word_packer
    import aesha_pkg::*;
#(
    parameter int WORD_W = 32
) (
    input  logic                    clock_i,
    input  logic                    reset_i,
    input  logic                    clear_i,
    input  logic                    wrEn_i,
    input  logic [IDX_W-1:0]        wrIdx_i,
    input  logic [WORD_W-1:0]       wrData_i,
    input  logic                    ldEn_i,
    input  logic [WORDS*WORD_W-1:0] ldData_i,
    input  logic [IDX_W-1:0]        rdIdx_i,
    output logic [WORD_W-1:0]       rdData_o,
    output logic [WORDS*WORD_W-1:0] block_o
);

    logic [WORD_W-1:0] words_q [WORDS];

    // An indexed write wins over clear so beat 0 can clear the block and land in one cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            for (int i = 0; i < WORDS; i++) begin
                words_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < WORDS; i++) begin
                if (ldEn_i) begin
                    words_q[i] <= ldData_i[i*WORD_W +: WORD_W];
                end else if (wrEn_i && (wrIdx_i == IDX_W'(i))) begin
                    words_q[i] <= wrData_i;
                end else if (clear_i) begin
                    words_q[i] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < WORDS; g++) begin : gFlatten
        assign block_o[g*WORD_W +: WORD_W] = words_q[g];
    end

    assign rdData_o = words_q[rdIdx_i];

endmodule

// File: rtl/aesha_stream_adapter.sv
// Ready/valid front/back end for the AESHA core: packs 32-bit beats into a 512-bit block,
// launches the core, captures its result and streams it back as 16 words.
module aesha_stream_adapter
    import aesha_pkg::*;
#(
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = 512
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_aes_or_keccak,
    input  logic               i_enc_or_dec,
    input  logic [127:0]       i_key,
    input  logic               i_s_valid,
    output logic               o_s_ready,
    input  logic [WORD_W-1:0]  i_s_data,
    input  logic               i_s_last,
    output logic               o_m_valid,
    input  logic               i_m_ready,
    output logic [WORD_W-1:0]  o_m_data,
    output logic               o_m_last,
    output logic               o_core_start,
    output logic               o_core_aes_or_keccak,
    output logic               o_core_enc_or_dec,
    output logic [127:0]       o_core_key,
    output logic [BLOCK_W-1:0] o_core_data,
    input  logic               i_core_done,
    input  logic [BLOCK_W-1:0] i_core_data,
    output logic               o_busy
);

    adapter_state_t   state_q, state_d;
    logic [IDX_W-1:0] inIdx_q, inIdx_d;
    logic [IDX_W-1:0] outIdx_q, outIdx_d;
    logic             sReady_q, sReady_d;
    logic             mode_q, mode_d;
    logic             dir_q, dir_d;
    logic [127:0]     key_q, key_d;

    logic               inWrEn;
    logic               inClear;
    logic               outLdEn;
    logic [WORD_W-1:0]  inRdData;
    logic [BLOCK_W-1:0] outBlock;
    logic               unusedBits;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q  <= LOAD;
            inIdx_q  <= '0;
            outIdx_q <= '0;
            sReady_q <= 1'b0;
            mode_q   <= 1'b0;
            dir_q    <= 1'b0;
            key_q    <= '0;
        end else begin
            state_q  <= state_d;
            inIdx_q  <= inIdx_d;
            outIdx_q <= outIdx_d;
            sReady_q <= sReady_d;
            mode_q   <= mode_d;
            dir_q    <= dir_d;
            key_q    <= key_d;
        end
    end

    // Ready is registered from the next state so it stays low while reset is held.
    always_comb begin
        state_d  = state_q;
        inIdx_d  = inIdx_q;
        outIdx_d = outIdx_q;
        mode_d   = mode_q;
        dir_d    = dir_q;
        key_d    = key_q;
        inWrEn   = 1'b0;
        inClear  = 1'b0;
        outLdEn  = 1'b0;

        case (state_q)
            LOAD: begin
                if (i_s_valid && sReady_q) begin
                    inWrEn = 1'b1;
                    if (inIdx_q == '0) begin
                        inClear = 1'b1;
                        mode_d  = i_aes_or_keccak;
                        dir_d   = i_enc_or_dec;
                        key_d   = i_key;
                    end
                    if (i_s_last || (inIdx_q == LAST_IDX)) begin
                        inIdx_d = '0;
                        state_d = LAUNCH;
                    end else begin
                        inIdx_d = inIdx_q + 1'b1;
                    end
                end
            end
            LAUNCH: begin
                state_d = WAIT;
            end
            WAIT: begin
                if (i_core_done) begin
                    outLdEn = 1'b1;
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (i_m_ready) begin
                    if (outIdx_q == LAST_IDX) begin
                        outIdx_d = '0;
                        state_d  = LOAD;
                    end else begin
                        outIdx_d = outIdx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = LOAD;
            end
        endcase

        sReady_d = (state_d == LOAD);
    end

    aesha_word_packer #(
        .WORD_W(WORD_W)
    ) uInPack (
        .clock_i (i_clk),
        .reset_i (i_reset),
        .clear_i (inClear),
        .wrEn_i  (inWrEn),
        .wrIdx_i (inIdx_q),
        .wrData_i(i_s_data),
        .ldEn_i  (1'b0),
        .ldData_i('0),
        .rdIdx_i ('0),
        .rdData_o(inRdData),
        .block_o (o_core_data)
    );

    aesha_word_packer #(
        .WORD_W(WORD_W)
    ) uOutPack (
        .clock_i (i_clk),
        .reset_i (i_reset),
        .clear_i (1'b0),
        .wrEn_i  (1'b0),
        .wrIdx_i ('0),
        .wrData_i('0),
        .ldEn_i  (outLdEn),
        .ldData_i(i_core_data),
        .rdIdx_i (outIdx_q),
        .rdData_o(o_m_data),
        .block_o (outBlock)
    );

    assign unusedBits = ^{inRdData, outBlock};

    assign o_s_ready            = sReady_q;
    assign o_m_valid            = (state_q == DRAIN);
    assign o_m_last             = (state_q == DRAIN) && (outIdx_q == LAST_IDX);
    assign o_core_start         = (state_q == LAUNCH);
    assign o_busy               = (state_q != LOAD);
    assign o_core_aes_or_keccak = mode_q;
    assign o_core_enc_or_dec    = dir_q;
    assign o_core_key           = key_q;

endmodule

// File: doc/aesha_stream_adapter.md
# aesha_stream_adapter

Streaming front/back end for the AESHA core. It accepts 32-bit words on a ready/valid input stream and packs them into the core's 512-bit block, with zero-fill for short blocks. It latches the mode, direction and key, launches the core, and captures the 512-bit result. The result is returned as 16 words on a ready/valid output stream. The adapter sits between the SoC bus bridge and AESHA_top and owns all handshaking with the core.

## Interface
- WORD_W, 32, stream word width
- BLOCK_W, 512, core block width; WORDS = BLOCK_W/WORD_W = 16
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-high reset
- i_aes_or_keccak  in  1  mode (1 = AES-128, 0 = SHA-3), sampled on the first beat of a block
- i_enc_or_dec  in  1  AES direction (0 = enc, 1 = dec), sampled on the first beat
- i_key  in  128  AES key, sampled on the first beat
- i_s_valid / o_s_ready  in/out  1  input handshake
- i_s_data  in  WORD_W  input word
- i_s_last  in  1  last word of block
- o_m_valid / i_m_ready  out/in  1  output handshake
- o_m_data  out  WORD_W  output word
- o_m_last  out  1  marks output beat 15
- o_core_start  out  1  one-cycle launch pulse to the core
- o_core_aes_or_keccak, o_core_enc_or_dec  out  1  latched config, stable from LAUNCH through WAIT
- o_core_key  out  128  latched key
- o_core_data  out  BLOCK_W  packed block
- i_core_done  in  1  core completion pulse
- i_core_data  in  BLOCK_W  core result
- o_busy  out  1  high in every state except LOAD

## Operation
- FSM states: LOAD, LAUNCH, WAIT, DRAIN.
- LOAD:
  - o_s_ready = 1.
  - Accepted beat k is written to o_core_data[32k+31:32k]; beat 0 is the LSW.
  - Beat 0 also latches the config and key, and clears the block register to zero.
  - The block closes on the s_last beat or on beat 15, whichever comes first; s_last is ignored once beat 15 has closed the block.
  - Words not written stay zero, so a 4-beat block equals a 128-bit value zero-extended.
  - Transition → LAUNCH.
- LAUNCH:
  - o_core_start = 1 for exactly one cycle.
  - Transition → WAIT.
- WAIT:
  - Holds all core inputs.
  - On i_core_done = 1, capture i_core_data into the result register.
  - Transition → DRAIN.
- DRAIN:
  - o_m_valid = 1 and o_m_data = result word j, for j = 0..15.
  - j advances on each handshake.
  - o_m_last = 1 when j = 15.
  - After the beat-15 handshake: j → 0 and state → LOAD.
- i_core_done outside WAIT is ignored.
- Counters are 4-bit and wrap only through the FSM: 15 → 0 on block close or drain end.
- Reset values:
  - Outputs: o_s_ready = 0 while reset is asserted, then 1 (LOAD); o_m_valid, o_m_last, o_core_start, o_busy = 0.
  - Registers: all data, key and config registers = 0; counters = 0; state = LOAD.
- Reset asserted mid-operation (any state) clears everything immediately. A pending output block is discarded; a partially loaded block is discarded.

## Timing
- The s_last handshake at edge N puts the FSM in LAUNCH in cycle N+1. o_core_start is high in that cycle.
- WAIT lasts until i_core_done. o_m_valid is high in the cycle after the done cycle.
- o_m_data/o_m_last stay stable while o_m_valid = 1 and i_m_ready = 0.
- Throughput with no back-pressure:
  - n input beats, + 1 LAUNCH cycle, + core latency, + 16 output beats.
  - There is no overlap between load and drain; o_s_ready = 0 during DRAIN.
- All outputs are registered. No combinational path from i_m_ready or i_s_valid to any output.

## Structure
- aesha_pkg holds:
  - the WORDS constant and index width;
  - the typedef enum logic [1:0] {LOAD, LAUNCH, WAIT, DRAIN} adapter_state_t;
  - the mode/direction localparams (MODE_AES = 1, DIR_DEC = 1).
- One sub-module is natural: aesha_word_packer. It is a 16×32 register array with clear, indexed write and indexed read, and is instantiated twice (input pack and output unpack).

## Test plan
- **AES enc, FIPS-197:**
  - Stimulus: mode = 1, dir = 0, key = 2b7e151628aed2a6abf7158809cf4f3c; beats e0370734, 313198a2, 885a308d, 3243f6a8 with last on beat 3.
  - Core input: o_core_data = 512'h3243f6a8885a308d313198a2e0370734.
  - Output (with AESHA_top attached): beat0 = 196a0b32, beat3 = 3925841d, beat4 = b91b546f, beat15 = 7df76b0c with o_m_last.
- **SHA-3, all zero:**
  - Stimulus: mode = 0; 16 zero beats, s_last low throughout.
  - Closure: the block closes on beat 15.
  - Output: beat15 = a8620b2e, beat0 = 975e995c.
- **Back-pressure:** hold i_m_ready = 0 for 5 cycles at beat 7. Required: o_m_data is stable, no beat is lost or duplicated, and exactly 16 beats are delivered.
- **Spurious done:** pulse i_core_done during LOAD and DRAIN. Required: no state change and no result overwrite.
- **Reset mid-operation:**
  - Assert i_reset during WAIT and again after DRAIN beat 5.
  - Required: all outputs are 0, state is LOAD, and the next block packs from zero with no leftover words.
- **Config latch:** change i_key and i_aes_or_keccak after beat 0. Required: o_core_key and the mode outputs keep the beat-0 values.
